// File: rtl/pow2_convert_pipe.sv
// rtl/pow2_convert_pipe.sv - pipelined log2-to-linear fixed-point converter
module pow2_convert_pipe #(
  parameter int FRAC_BITS = 8,
  parameter int INT_BITS  = 4,
  parameter int OUT_WIDTH = 16,
  parameter int OUT_FRAC  = 8,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_zero,
  input  logic [INT_BITS-1:0]  in_exp,
  input  logic [FRAC_BITS-1:0] in_frac,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_ovf,
  output logic                 out_unf,
  output logic [TAG_WIDTH-1:0] out_tag
);
  // Mantissa 1.m with FRAC_BITS+1 fraction bits; shift amount kept in a
  // generous signed width; result wide enough to see any overflow bit.
  localparam int MW = FRAC_BITS + 2;
  localparam int SW = 16;
  localparam int RW = MW + OUT_WIDTH + 1;
  localparam logic signed [SW-1:0] S_OVF = SW'(OUT_WIDTH);
  localparam logic [SW-1:0]        N_MAX = SW'(MW);

  if (FRAC_BITS < 4 || FRAC_BITS > 10) begin : g_bad_frac
    $error("pow2_convert_pipe: FRAC_BITS must be within 4..10");
  end
  if (OUT_FRAC > OUT_WIDTH) begin : g_bad_out
    $error("pow2_convert_pipe: OUT_FRAC must not exceed OUT_WIDTH");
  end

  // Table entry round_half_up((2^(k/2^F) - 1) * 2^(F+1)), evaluated in Q60
  // integer arithmetic: ln2 from its series, then exp() by Taylor series.
  function automatic logic [FRAC_BITS:0] lut_entry(input int k);
    logic [127:0] one, ln2, x, term, sum, v, nn;
    one = 128'd1 << 60;
    ln2 = '0;
    for (int n = 1; n <= 62; n++) begin
      nn  = 128'(n);
      ln2 = ln2 + ((one >> n) / nn);
    end
    x    = ((128'(k) << (60 - FRAC_BITS)) * ln2) >> 60;
    term = one;
    sum  = one;
    for (int n = 1; n <= 24; n++) begin
      nn   = 128'(n);
      term = ((term * x) >> 60) / nn;
      sum  = sum + term;
    end
    v = (((sum - one) << (FRAC_BITS + 1)) + (one >> 1)) >> 60;
    if (v > 128'((1 << (FRAC_BITS + 1)) - 1)) begin
      v = 128'((1 << (FRAC_BITS + 1)) - 1);
    end
    return v[FRAC_BITS:0];
  endfunction

  logic [FRAC_BITS:0] w_lut [2**FRAC_BITS];
  for (genvar g = 0; g < 2**FRAC_BITS; g++) begin : g_lut
    localparam logic [FRAC_BITS:0] LV = lut_entry(g);
    assign w_lut[g] = LV;
  end

  logic                  r1_v, r1_zero;
  logic [INT_BITS-1:0]   r1_exp;
  logic [FRAC_BITS-1:0]  r1_frac;
  logic [TAG_WIDTH-1:0]  r1_tag;
  logic                  r2_v, r2_zero;
  logic [MW-1:0]         r2_m;
  logic signed [SW-1:0]  r2_s;
  logic [TAG_WIDTH-1:0]  r2_tag;
  logic                  r3_v, r3_ovf, r3_unf;
  logic [OUT_WIDTH-1:0]  r3_data;
  logic [TAG_WIDTH-1:0]  r3_tag;

  // A stage may load when it is empty or its successor is taking its word.
  logic w_ld1, w_ld2, w_ld3;
  assign w_ld3    = !r3_v || out_ready;
  assign w_ld2    = !r2_v || w_ld3;
  assign w_ld1    = !r1_v || w_ld2;
  assign in_ready = w_ld1;

  logic signed [SW-1:0] w_s;
  assign w_s = SW'($signed(r1_exp)) + SW'(OUT_FRAC - FRAC_BITS - 1);

  // S1: capture the accepted input word.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r1_v    <= 1'b0;
      r1_zero <= 1'b0;
      r1_exp  <= '0;
      r1_frac <= '0;
      r1_tag  <= '0;
    end else if (w_ld1) begin
      r1_v <= in_valid;
      if (in_valid) begin
        r1_zero <= in_zero;
        r1_exp  <= in_exp;
        r1_frac <= in_frac;
        r1_tag  <= in_tag;
      end
    end
  end

  // S2: mantissa from the table and the net shift toward the output format.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r2_v    <= 1'b0;
      r2_zero <= 1'b0;
      r2_m    <= '0;
      r2_s    <= '0;
      r2_tag  <= '0;
    end else if (w_ld2) begin
      r2_v <= r1_v;
      if (r1_v) begin
        r2_zero <= r1_zero;
        r2_m    <= {1'b1, w_lut[r1_frac]};
        r2_s    <= w_s;
        r2_tag  <= r1_tag;
      end
    end
  end

  logic [SW-1:0]        w_n;
  logic [RW-1:0]        w_r;
  logic                 w_big, w_ovf, w_unf;
  logic [OUT_WIDTH-1:0] w_data;

  // Shift with round-half-up on right shifts, then saturate or flush.
  // A left shift of OUT_WIDTH or more always overflows since M's MSB is set.
  always_comb begin
    w_n    = '0;
    w_r    = '0;
    w_big  = 1'b0;
    w_ovf  = 1'b0;
    w_unf  = 1'b0;
    w_data = '0;
    if (!r2_s[SW-1]) begin
      if (r2_s >= S_OVF) begin
        w_big = 1'b1;
      end else begin
        w_r = RW'(r2_m) << r2_s;
      end
    end else begin
      w_n = -r2_s;
      if (w_n <= N_MAX) begin
        w_r = (RW'(r2_m) + (RW'(1) << (w_n - SW'(1)))) >> w_n;
      end
    end
    if (!r2_zero) begin
      if (w_big || ((w_r >> OUT_WIDTH) != '0)) begin
        w_data = '1;
        w_ovf  = 1'b1;
      end else if (w_r == '0) begin
        w_unf = 1'b1;
      end else begin
        w_data = w_r[OUT_WIDTH-1:0];
      end
    end
  end

  // S3: output register, held while downstream stalls.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r3_v    <= 1'b0;
      r3_data <= '0;
      r3_ovf  <= 1'b0;
      r3_unf  <= 1'b0;
      r3_tag  <= '0;
    end else if (w_ld3) begin
      r3_v <= r2_v;
      if (r2_v) begin
        r3_data <= w_data;
        r3_ovf  <= w_ovf;
        r3_unf  <= w_unf;
        r3_tag  <= r2_tag;
      end
    end
  end

  assign out_valid = r3_v;
  assign out_data  = r3_data;
  assign out_ovf   = r3_ovf;
  assign out_unf   = r3_unf;
  assign out_tag   = r3_tag;

endmodule

// File: tb/tb_pow2_convert_pipe.sv
// tb/tb_pow2_convert_pipe.sv - scoreboard bench for pow2_convert_pipe
module tb_pow2_convert_pipe;
  logic       clock = 1'b0;
  logic       resetn;
  logic       t_iv, t_z, ordy;
  logic [4:0] t_e;
  logic [9:0] t_f;
  logic [3:0] t_tag;
  int         sel;

  always #5 clock = ~clock;

  logic        d0_ird, d0_ov, d0_ovf, d0_unf;
  logic [15:0] d0_data;
  logic [3:0]  d0_tag;
  logic        d1_ird, d1_ov, d1_ovf, d1_unf;
  logic [11:0] d1_data;
  logic [3:0]  d1_tag;
  logic        d2_ird, d2_ov, d2_ovf, d2_unf;
  logic [15:0] d2_data;
  logic [3:0]  d2_tag;
  logic        d3_ird, d3_ov, d3_ovf, d3_unf;
  logic [15:0] d3_data;
  logic [3:0]  d3_tag;

  pow2_convert_pipe u_d0 (
    .clock(clock), .resetn(resetn), .in_valid(t_iv && sel == 0), .in_ready(d0_ird),
    .in_zero(t_z), .in_exp(t_e[3:0]), .in_frac(t_f[7:0]), .in_tag(t_tag),
    .out_valid(d0_ov), .out_ready(ordy), .out_data(d0_data), .out_ovf(d0_ovf),
    .out_unf(d0_unf), .out_tag(d0_tag));

  pow2_convert_pipe #(.OUT_WIDTH(12)) u_d1 (
    .clock(clock), .resetn(resetn), .in_valid(t_iv && sel == 1), .in_ready(d1_ird),
    .in_zero(t_z), .in_exp(t_e[3:0]), .in_frac(t_f[7:0]), .in_tag(t_tag),
    .out_valid(d1_ov), .out_ready(ordy), .out_data(d1_data), .out_ovf(d1_ovf),
    .out_unf(d1_unf), .out_tag(d1_tag));

  pow2_convert_pipe #(.FRAC_BITS(6), .INT_BITS(5), .OUT_FRAC(7)) u_d2 (
    .clock(clock), .resetn(resetn), .in_valid(t_iv && sel == 2), .in_ready(d2_ird),
    .in_zero(t_z), .in_exp(t_e), .in_frac(t_f[5:0]), .in_tag(t_tag),
    .out_valid(d2_ov), .out_ready(ordy), .out_data(d2_data), .out_ovf(d2_ovf),
    .out_unf(d2_unf), .out_tag(d2_tag));

  pow2_convert_pipe #(.FRAC_BITS(10), .OUT_FRAC(11)) u_d3 (
    .clock(clock), .resetn(resetn), .in_valid(t_iv && sel == 3), .in_ready(d3_ird),
    .in_zero(t_z), .in_exp(t_e[3:0]), .in_frac(t_f), .in_tag(t_tag),
    .out_valid(d3_ov), .out_ready(ordy), .out_data(d3_data), .out_ovf(d3_ovf),
    .out_unf(d3_unf), .out_tag(d3_tag));

  logic        m_ird, m_ov, m_ovf, m_unf;
  logic [15:0] m_data;
  logic [3:0]  m_tag;

  // Route the selected instance onto one set of monitor signals.
  always_comb begin
    m_ird = 1'b0; m_ov = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_data = '0; m_tag = '0;
    case (sel)
      0: begin m_ird = d0_ird; m_ov = d0_ov; m_ovf = d0_ovf; m_unf = d0_unf; m_data = d0_data; m_tag = d0_tag; end
      1: begin m_ird = d1_ird; m_ov = d1_ov; m_ovf = d1_ovf; m_unf = d1_unf; m_data = 16'(d1_data); m_tag = d1_tag; end
      2: begin m_ird = d2_ird; m_ov = d2_ov; m_ovf = d2_ovf; m_unf = d2_unf; m_data = d2_data; m_tag = d2_tag; end
      default: begin m_ird = d3_ird; m_ov = d3_ov; m_ovf = d3_ovf; m_unf = d3_unf; m_data = d3_data; m_tag = d3_tag; end
    endcase
  end

  typedef struct {
    int   data;
    logic ovf;
    logic unf;
    int   tag;
    int   acc;
    logic lat;
  } sb_t;

  sb_t  sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   inflight = 0;
  logic lat_on = 1'b0;
  logic pat_on = 1'b0;
  int   ph = 0;
  logic hold_chk = 1'b0;
  logic [22:0] held;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model(input int fb, input int ow, input int ofr, input logic z,
                                input int e, input int f, output int xd, output logic xo,
                                output logic xu);
    real lutv, m, r, lim;
    int  s;
    lutv = $floor(($pow(2.0, real'(f) / real'(1 << fb)) - 1.0) * real'(1 << (fb + 1)) + 0.5);
    lim  = real'((1 << (fb + 1)) - 1);
    if (lutv > lim) lutv = lim;
    m = real'(1 << (fb + 1)) + lutv;
    s = e + ofr - (fb + 1);
    r = m * $pow(2.0, real'(s));
    if (s < 0) r = $floor(r + 0.5);
    xd = 0; xo = 1'b0; xu = 1'b0;
    if (!z) begin
      if (r >= $pow(2.0, real'(ow))) begin
        xd = (1 << ow) - 1;
        xo = 1'b1;
      end else if (r < 0.5) begin
        xu = 1'b1;
      end else begin
        xd = $rtoi(r);
      end
    end
  endfunction

  always @(posedge clock) cyc++;

  // 1-on/2-off downstream ready pattern for the stall test.
  always @(posedge clock) begin
    if (pat_on) begin
      #1;
      ph   = (ph == 2) ? 0 : ph + 1;
      ordy = (ph == 0);
    end
  end

  // Monitor: handshake model, hold stability, scoreboard pop, latency.
  always @(negedge clock) begin
    if (resetn) begin
      sb_t ent;
      chk("in_ready", 32'(m_ird), 32'(!(inflight == 3 && !ordy)));
      if (hold_chk) begin
        chk("hold_valid", 32'(m_ov), 32'd1);
        chk("hold_word", 32'({m_data, m_ovf, m_unf, m_tag}), 32'(held));
      end
      hold_chk = m_ov && !ordy;
      held     = {m_data, m_ovf, m_unf, m_tag};
      if (m_ov && ordy) begin
        if (sb.size() == 0) begin
          chk("unexp_out", 32'(m_ov), 32'd0);
        end else begin
          ent = sb.pop_front();
          chk("data", 32'(m_data), 32'(ent.data));
          chk("ovf", 32'(m_ovf), 32'(ent.ovf));
          chk("unf", 32'(m_unf), 32'(ent.unf));
          chk("tag", 32'(m_tag), 32'(ent.tag));
          if (ent.lat) chk("latency", 32'(cyc - ent.acc), 32'd3);
          inflight--;
        end
      end
      if (t_iv && m_ird) begin
        inflight++;
        if (sb.size() > 0) sb[sb.size() - 1].acc = cyc;
      end
    end
  end

  task automatic send_x(input logic z, input int e, input int f, input int tag,
                        input int xd, input logic xo, input logic xu);
    sb_t  ent;
    logic got;
    ent.data = xd; ent.ovf = xo; ent.unf = xu; ent.tag = tag & 15;
    ent.acc = -1000; ent.lat = lat_on;
    sb.push_back(ent);
    t_iv = 1'b1; t_z = z; t_e = 5'(e); t_f = 10'(f); t_tag = 4'(tag);
    got = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clock);
      if (m_ird) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("accept_timeout", 32'(m_ird), 32'd1);
    @(posedge clock);
    #1;
    t_iv = 1'b0;
  endtask

  task automatic send_m(input logic z, input int e, input int f, input int tag);
    int   fb, ow, ofr, xd;
    logic xo, xu;
    fb  = (sel == 2) ? 6 : (sel == 3) ? 10 : 8;
    ow  = (sel == 1) ? 12 : 16;
    ofr = (sel == 2) ? 7 : (sel == 3) ? 11 : 8;
    model(fb, ow, ofr, z, e, f, xd, xo, xu);
    send_x(z, e, f, tag, xd, xo, xu);
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && sb.size() != 0; n++) @(posedge clock);
    #3;
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    resetn = 1'b0; t_iv = 1'b0; t_z = 1'b0; t_e = '0; t_f = '0; t_tag = '0;
    ordy = 1'b1; sel = 0;
    repeat (2) @(negedge clock);
    chk("rst_valid", 32'(m_ov), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_flags", 32'({m_ovf, m_unf}), 32'd0);
    chk("rst_tag", 32'(m_tag), 32'd0);
    chk("rst_ready", 32'(m_ird), 32'd1);
    @(posedge clock); #1;
    resetn = 1'b1;
    lat_on = 1'b1;

    // Basic conversions and table check values through a shift of zero.
    send_x(1'b0, 0, 0, 1, 256, 1'b0, 1'b0);
    send_x(1'b0, 0, 128, 2, 362, 1'b0, 1'b0);
    send_x(1'b0, 1, 1, 3, 513, 1'b0, 1'b0);
    send_x(1'b0, 1, 2, 4, 515, 1'b0, 1'b0);
    send_x(1'b0, 1, 128, 5, 724, 1'b0, 1'b0);
    send_x(1'b1, 5, 77, 6, 0, 1'b0, 1'b0);
    send_m(1'b0, -8, 0, 7);
    send_m(1'b0, 7, 255, 8);
    for (int i = 0; i < 24; i++) begin
      send_m($urandom_range(0, 7) == 0, $urandom_range(0, 15) - 8, $urandom_range(0, 255), i);
    end
    drain();

    // Saturation on a 12-bit output.
    sel = 1;
    send_x(1'b0, 3, 0, 9, 2048, 1'b0, 1'b0);
    send_x(1'b0, 4, 0, 10, 4095, 1'b1, 1'b0);
    send_m(1'b0, 7, 200, 11);
    drain();

    // Full fraction sweeps, plus an underflow flush.
    sel = 2;
    for (int f = 0; f < 64; f++) send_m(1'b0, 0, f, f);
    send_x(1'b0, -16, 0, 12, 0, 1'b0, 1'b1);
    send_x(1'b1, -16, 0, 13, 0, 1'b0, 1'b0);
    drain();
    sel = 3;
    for (int f = 0; f < 1024; f++) send_m(1'b0, 0, f, f);
    drain();

    // Back-to-back stream against a stalling consumer.
    sel = 0;
    lat_on = 1'b0;
    @(posedge clock); #3;
    ph = 0;
    pat_on = 1'b1;
    for (int i = 0; i < 16; i++) send_m(1'b0, $urandom_range(0, 15) - 8, $urandom_range(0, 255), i);
    for (int n = 0; n < 200 && sb.size() != 0; n++) @(posedge clock);
    @(posedge clock); #3;
    pat_on = 1'b0;
    ordy = 1'b1;
    drain();

    // Asynchronous reset with a full pipe.
    @(posedge clock); #3;
    ordy = 1'b0;
    send_m(1'b0, 1, 10, 1);
    send_m(1'b0, 2, 20, 2);
    send_m(1'b0, 3, 30, 3);
    #1;
    resetn = 1'b0;
    #1;
    chk("async_valid", 32'(m_ov), 32'd0);
    chk("async_data", 32'(m_data), 32'd0);
    chk("async_ready", 32'(m_ird), 32'd1);
    #1;
    resetn = 1'b1;
    sb.delete();
    inflight = 0;
    hold_chk = 1'b0;
    ordy = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    lat_on = 1'b1;
    send_x(1'b0, 0, 0, 14, 256, 1'b0, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
